// File: rtl/relu_maxpool_layer.sv
// ReLU + non-overlapping 1D max-pool over a flattened K-channel sign-magnitude map, one element per clock.
// Optional macro RELU_MAXPOOL_RELU_EN enables the ReLU; when undefined, pooling runs on raw sign-magnitude codes.
module relu_maxpool_layer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned K          = 4,
    parameter int unsigned L          = 128,
    parameter int unsigned PS         = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [0:K*L*DATA_WIDTH-1]            conv_data,
    output logic [0:K*(L/PS)*DATA_WIDTH-1]       pool_out,
    output logic                                 done_flag
);

    localparam int unsigned NOUT  = K * (L / PS);
    localparam int unsigned CH_W  = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned POS_W = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned WIN_W = (PS > 1) ? $clog2(PS) : 1;
    localparam int unsigned IDX_W = (K * L > 1) ? $clog2(K * L) : 1;
    localparam int unsigned OUT_W = (NOUT > 1) ? $clog2(NOUT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [CH_W-1:0]         ch;
    logic [POS_W-1:0]        pos;
    logic [WIN_W-1:0]        win;
    logic [OUT_W-1:0]        out_idx;
    logic [DATA_WIDTH-1:0]   run_max;

    logic [IDX_W-1:0]        elem_idx;
    logic [DATA_WIDTH-1:0]   cur;
    logic [DATA_WIDTH-1:0]   best;

    // Input conditioning: ReLU clamps every negative code (including -0) to +0.
    function automatic logic [DATA_WIDTH-1:0] prep(input logic [DATA_WIDTH-1:0] x);
`ifdef RELU_MAXPOOL_RELU_EN
        prep = x[DATA_WIDTH-1] ? '0 : x;
`else
        prep = x;
`endif
    endfunction

    // Maps a sign-magnitude code onto an unsigned ordering key; +0 and -0 share one key.
    function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
        if (x[DATA_WIDTH-2:0] == '0)
            order_key = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else if (x[DATA_WIDTH-1])
            order_key = {1'b0, ~x[DATA_WIDTH-2:0]};
        else
            order_key = {1'b1, x[DATA_WIDTH-2:0]};
    endfunction

    always_comb begin
        elem_idx = IDX_W'(ch) * IDX_W'(L) + IDX_W'(pos);
        cur      = prep(conv_data[elem_idx*DATA_WIDTH +: DATA_WIDTH]);
        // First element of a window loads; later ones replace only when strictly greater.
        best     = ((win == '0) || (order_key(cur) > order_key(run_max))) ? cur : run_max;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ch        <= '0;
            pos       <= '0;
            win       <= '0;
            out_idx   <= '0;
            run_max   <= '0;
            pool_out  <= '0;
            done_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_flag <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        ch      <= '0;
                        pos     <= '0;
                        win     <= '0;
                        out_idx <= '0;
                    end
                end
                RUN: begin
                    if (!start) begin
                        state     <= IDLE;
                        done_flag <= 1'b0;
                    end else begin
                        run_max <= best;
                        if (win == WIN_W'(PS - 1)) begin
                            pool_out[out_idx*DATA_WIDTH +: DATA_WIDTH] <= best;
                            win     <= '0;
                            out_idx <= out_idx + OUT_W'(1);
                        end else begin
                            win <= win + WIN_W'(1);
                        end
                        // Windows never straddle channels because PS divides L.
                        if (pos == POS_W'(L - 1)) begin
                            pos <= '0;
                            if (ch == CH_W'(K - 1)) begin
                                ch        <= '0;
                                state     <= DONE;
                                done_flag <= 1'b1;
                            end else begin
                                ch <= ch + CH_W'(1);
                            end
                        end else begin
                            pos <= pos + POS_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        state     <= IDLE;
                        done_flag <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_maxpool_layer.sv
// Self-checking bench for relu_maxpool_layer: randomized maps against a signed-integer pooling model.
module tb_relu_maxpool_layer;

    localparam int unsigned DW   = 16;
    localparam int unsigned K    = 4;
    localparam int unsigned L    = 128;
    localparam int unsigned PS   = 2;
    localparam int unsigned NE   = K * L;
    localparam int unsigned NO   = L / PS;
    localparam int unsigned NOUT = K * NO;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic [0:NE*DW-1]     conv_data = '0;
    logic [0:NOUT*DW-1]   pool_out;
    logic                 done_flag;

    logic [DW-1:0] mem     [NE];
    logic [DW-1:0] exp_out [NOUT];
    int errors = 0;
    int checks = 0;

    relu_maxpool_layer #(.DATA_WIDTH(DW), .K(K), .L(L), .PS(PS)) dut (
        .clk(clk), .reset(reset), .start(start),
        .conv_data(conv_data), .pool_out(pool_out), .done_flag(done_flag)
    );

    always #5 clk = ~clk;

    function automatic int sm_val(input logic [DW-1:0] x);
        return x[DW-1] ? -int'(x[DW-2:0]) : int'(x[DW-2:0]);
    endfunction

    // Reference: per window, pick the first element with the greatest numeric value.
    task automatic compute_model();
        for (int c = 0; c < K; c++) begin
            for (int j = 0; j < NO; j++) begin
                logic [DW-1:0] bc;
                int bv;
                bc = '0;
                bv = 0;
                for (int k = 0; k < PS; k++) begin
                    logic [DW-1:0] e;
                    e = mem[c*L + j*PS + k];
`ifdef RELU_MAXPOOL_RELU_EN
                    if (e[DW-1]) e = '0;
`endif
                    if (k == 0 || sm_val(e) > bv) begin
                        bv = sm_val(e);
                        bc = e;
                    end
                end
                exp_out[c*NO + j] = bc;
            end
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NE; i++) conv_data[i*DW +: DW] = mem[i];
    endtask

    function automatic logic [DW-1:0] rand_elem();
        logic [DW-1:0] r;
        case ($urandom_range(0, 3))
            0: r = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 3))};
            1: r = $urandom_range(0, 1) ? 16'h8000 : 16'h0000;
            default: r = 16'($urandom);
        endcase
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NE; i++) mem[i] = rand_elem();
    endtask

    task automatic compare_all(input string name);
        for (int i = 0; i < NOUT; i++) begin
            logic [DW-1:0] got;
            got = pool_out[i*DW +: DW];
            checks++;
            if (got !== exp_out[i]) begin
                errors++;
                $display("FAIL %s pool[%0d] got=%h exp=%h", name, i, got, exp_out[i]);
            end
        end
    endtask

    // Full run: done must rise exactly at edge K*L+1, hold while start=1, fall when start drops.
    task automatic run_and_check(input string name, input bit skip_wait);
        int edges;
        bit seen;
        drive_inputs();
        compute_model();
        if (!skip_wait) @(negedge clk);
        start = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < NE + 20) begin
            @(posedge clk); #1;
            edges++;
            if (done_flag === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || edges != NE + 1) begin
            errors++;
            $display("FAIL %s done_edge got=%0d exp=%0d", name, edges, NE + 1);
        end
        compare_all(name);
        @(posedge clk); #1;
        checks++;
        if (done_flag !== 1'b1) begin
            errors++;
            $display("FAIL %s done_hold got=%b exp=1", name, done_flag);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done_flag !== 1'b0) begin
            errors++;
            $display("FAIL %s done_fall got=%b exp=0", name, done_flag);
        end
        checks++;
        if (pool_out[0 +: DW] !== exp_out[0]) begin
            errors++;
            $display("FAIL %s retain got=%h exp=%h", name, pool_out[0 +: DW], exp_out[0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if (done_flag !== 1'b0 || pool_out !== '0) begin
            errors++;
            $display("FAIL reset_async done=%b nonzero_bits=%0d exp done=0 bits=0",
                     done_flag, $countones(pool_out));
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (done_flag !== 1'b0 || pool_out !== '0) begin
            errors++;
            $display("FAIL reset_idle done=%b nonzero_bits=%0d exp done=0 bits=0",
                     done_flag, $countones(pool_out));
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < NE; i++) mem[i] = 16'h0003;
        mem[1] = 16'h0010;
        run_and_check("basic", 1'b0);
        checks++;
        if (pool_out[0 +: DW] !== 16'h0010) begin
            errors++;
            $display("FAIL basic_p0 got=%h exp=0010", pool_out[0 +: DW]);
        end
        checks++;
        if (pool_out[DW +: DW] !== 16'h0003) begin
            errors++;
            $display("FAIL basic_p1 got=%h exp=0003", pool_out[DW +: DW]);
        end
    endtask

    task automatic test_sign();
        logic [DW-1:0] e_neg, e_zero;
`ifdef RELU_MAXPOOL_RELU_EN
        e_neg  = 16'h0000;
        e_zero = 16'h0000;
`else
        e_neg  = 16'h8001;
        e_zero = 16'h8000;
`endif
        fill_random();
        mem[2*L + 10] = 16'h8005;
        mem[2*L + 11] = 16'h8001;
        mem[2*L + 12] = 16'h8000;
        mem[2*L + 13] = 16'h0000;
        run_and_check("sign", 1'b0);
        checks++;
        if (pool_out[(2*NO+5)*DW +: DW] !== e_neg) begin
            errors++;
            $display("FAIL sign_neg got=%h exp=%h", pool_out[(2*NO+5)*DW +: DW], e_neg);
        end
        checks++;
        if (pool_out[(2*NO+6)*DW +: DW] !== e_zero) begin
            errors++;
            $display("FAIL sign_zero got=%h exp=%h", pool_out[(2*NO+6)*DW +: DW], e_zero);
        end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < NE; i++) mem[i] = 16'h0000;
        mem[L-1] = 16'h7FFF;
        mem[L]   = 16'h0001;
        run_and_check("boundary", 1'b0);
        checks++;
        if (pool_out[(NO-1)*DW +: DW] !== 16'h7FFF) begin
            errors++;
            $display("FAIL bound_63 got=%h exp=7fff", pool_out[(NO-1)*DW +: DW]);
        end
        checks++;
        if (pool_out[NO*DW +: DW] !== 16'h0001) begin
            errors++;
            $display("FAIL bound_64 got=%h exp=0001", pool_out[NO*DW +: DW]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            fill_random();
            run_and_check("random", 1'b0);
        end
    endtask

    // Drop start so edge 100 samples 0; windows 0..48 finished by edge 99.
    task automatic test_abort();
        logic [DW-1:0] prev [NOUT];
        for (int i = 0; i < NOUT; i++) prev[i] = exp_out[i];
        fill_random();
        drive_inputs();
        compute_model();
        @(negedge clk);
        start = 1'b1;
        repeat (99) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done_flag !== 1'b0) begin
            errors++;
            $display("FAIL abort_done got=%b exp=0", done_flag);
        end
        for (int i = 0; i < NOUT; i++) begin
            logic [DW-1:0] want;
            want = (i < 49) ? exp_out[i] : prev[i];
            checks++;
            if (pool_out[i*DW +: DW] !== want) begin
                errors++;
                $display("FAIL abort_keep pool[%0d] got=%h exp=%h", i, pool_out[i*DW +: DW], want);
            end
        end
        fill_random();
        run_and_check("abort_rerun", 1'b0);
    endtask

    task automatic test_reset_mid();
        fill_random();
        drive_inputs();
        @(negedge clk);
        start = 1'b1;
        repeat (300) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (done_flag !== 1'b0 || pool_out !== '0) begin
            errors++;
            $display("FAIL reset_mid done=%b nonzero_bits=%0d exp done=0 bits=0",
                     done_flag, $countones(pool_out));
        end
        @(negedge clk);
        reset = 1'b0;
        fill_random();
        run_and_check("after_reset", 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_boundary();
        test_random();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
